// File: rtl/instr_encoder.sv
// Instruction encoder: packs DP/LDR/STR/B fields into 32-bit words, queues them
// in a 4-entry FIFO and streams them to instruction memory at an auto-incrementing address.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [3:0]  in_cmd,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rm,
    input  logic [23:0] in_imm,
    input  logic        base_load,
    input  logic [7:0]  base_addr,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  level,
    output logic        err,
    output logic        wrap
);

    localparam logic [2:0] KIND_B       = 3'b110;
    localparam logic [2:0] KIND_ILLEGAL = 3'b111;
    localparam logic [2:0] FIFO_DEPTH   = 3'd4;

    logic [31:0] fifo_q [0:3];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  level_q,  level_d;
    logic [7:0]  addr_q,   addr_d;
    logic        err_q,    err_d;
    logic        wrap_q,   wrap_d;

    logic [31:0] enc_word;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word        = '0;
        enc_word[31:28] = 4'b1110;
        if (in_kind == KIND_B) begin
            enc_word[27:26] = 2'b10;
            enc_word[23:0]  = in_imm;
        end else begin
            // kind[2:1]==00 is DP, otherwise a memory op; kind[0] selects the I form
            enc_word[27:26] = (in_kind[2:1] == 2'b00) ? 2'b00 : 2'b01;
            enc_word[25]    = in_kind[0];
            enc_word[24:21] = in_cmd;
            enc_word[20]    = in_kind[2];
            enc_word[19:16] = in_rn;
            enc_word[15:12] = in_rd;
            if (in_kind[0]) begin
                enc_word[7:0] = in_imm[7:0];
            end else begin
                enc_word[3:0] = in_rm;
            end
        end
    end

    assign in_ready = (level_q != FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_kind != KIND_ILLEGAL);
    assign pop      = (level_q != 3'd0) && mem_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        addr_d   = addr_q;
        err_d    = err_q;
        wrap_d   = wrap_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            level_d = level_q + 3'd1;
        end else if (pop && !push) begin
            level_d = level_q - 3'd1;
        end

        // An explicit base load overrides the post-write increment
        if (base_load) begin
            addr_d = base_addr;
        end else if (pop) begin
            addr_d = addr_q + 8'd1;
            if (addr_q == 8'hFF) begin
                wrap_d = 1'b1;
            end
        end

        if (accept && (in_kind == KIND_ILLEGAL)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    assign mem_we    = (level_q != 3'd0);
    // Stale storage is masked so an empty queue always presents zero data
    assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : '0;
    assign mem_addr  = addr_q;
    assign level     = level_q;
    assign err       = err_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO backpressure, address wrap,
// illegal kinds and mid-operation reset, all against hand-computed values.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [3:0]  in_cmd;
    logic [3:0]  in_rn;
    logic [3:0]  in_rd;
    logic [3:0]  in_rm;
    logic [23:0] in_imm;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        mem_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  level;
    logic        err;
    logic        wrap;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_cmd    (in_cmd),
        .in_rn     (in_rn),
        .in_rd     (in_rd),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .level     (level),
        .err       (err),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] kind, input logic [3:0] cmd, input logic [3:0] rn,
                        input logic [3:0] rd, input logic [3:0] rm, input logic [23:0] imm);
        in_kind  = kind;
        in_cmd   = cmd;
        in_rn    = rn;
        in_rd    = rd;
        in_rm    = rm;
        in_imm   = imm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [2:0] drain_lvl [5];

    initial begin
        drain_lvl = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        rst = 1'b0; in_valid = 1'b0; in_kind = '0; in_cmd = '0; in_rn = '0; in_rd = '0;
        in_rm = '0; in_imm = '0; base_load = 1'b0; base_addr = '0; mem_ready = 1'b0;
        tick(); tick();
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b1;

        // Encodings, one word at a time with memory always ready
        mem_ready = 1'b1;
        send(3'b001, 4'h4, 4'h1, 4'h2, 4'h0, 24'h000005);
        check("dpi_level", {29'd0, level}, 32'd1);
        check("dpi_we", {31'd0, mem_we}, 32'd1);
        check("dpi_word", mem_wdata, 32'hE2812005);
        check("dpi_addr", {24'd0, mem_addr}, 32'h00);
        tick();
        check("dpi_popped", {29'd0, level}, 32'd0);
        check("dpi_addr_inc", {24'd0, mem_addr}, 32'h01);
        send(3'b000, 4'h2, 4'h3, 4'h4, 4'h5, 24'hABCDEF);
        check("dpr_word", mem_wdata, 32'hE0434005);
        check("dpr_addr", {24'd0, mem_addr}, 32'h01);
        tick();
        send(3'b101, 4'hC, 4'h1, 4'h0, 4'hF, 24'hFFFF04);
        check("stri_word", mem_wdata, 32'hE7910004);
        check("stri_addr", {24'd0, mem_addr}, 32'h02);
        tick();
        send(3'b110, 4'hF, 4'hF, 4'hF, 4'hF, 24'h000010);
        check("b_word", mem_wdata, 32'hE8000010);
        check("b_addr", {24'd0, mem_addr}, 32'h03);
        tick();
        check("b_addr_inc", {24'd0, mem_addr}, 32'h04);

        send(3'b111, 4'h1, 4'h2, 4'h3, 4'h4, 24'h000005);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_level", {29'd0, level}, 32'd0);
        check("ill_we", {31'd0, mem_we}, 32'd0);
        tick();
        check("ill_sticky", {31'd0, err}, 32'd1);

        // Backpressure: fill with memory stalled, fifth word refused until a slot frees
        rst = 1'b0; tick(); rst = 1'b1;
        check("bp_err_clr", {31'd0, err}, 32'd0);
        mem_ready = 1'b0;
        in_kind = 3'b001; in_cmd = '0; in_rn = '0; in_rd = '0; in_rm = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_imm = 24'(k + 1);
            check($sformatf("bp_ready%0d", k), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("bp_level%0d", k), {29'd0, level}, 32'(k + 1));
        end
        in_imm = 24'd5;
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_full_refuse", {29'd0, level}, 32'd4);
        check("bp_hold_word", mem_wdata, 32'hE2000001);
        check("bp_hold_addr", {24'd0, mem_addr}, 32'h00);
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain_word%0d", k), mem_wdata, 32'hE2000001 + 32'(k));
            check($sformatf("drain_addr%0d", k), {24'd0, mem_addr}, 32'(k));
            tick();
            if (k == 1) in_valid = 1'b0;
            check($sformatf("drain_level%0d", k), {29'd0, level}, {29'd0, drain_lvl[k]});
        end
        check("drain_addr_end", {24'd0, mem_addr}, 32'h05);

        // Base load near the top of memory and wrap-around
        base_load = 1'b1; base_addr = 8'hFE;
        tick();
        base_load = 1'b0;
        check("base_addr", {24'd0, mem_addr}, 32'hFE);
        send(3'b001, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000001);
        check("wrap_a0", {24'd0, mem_addr}, 32'hFE);
        tick();
        check("wrap_pre", {31'd0, wrap}, 32'd0);
        send(3'b001, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000002);
        check("wrap_a1", {24'd0, mem_addr}, 32'hFF);
        tick();
        check("wrap_set", {31'd0, wrap}, 32'd1);
        send(3'b001, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000003);
        check("wrap_a2", {24'd0, mem_addr}, 32'h00);
        check("wrap_w2", mem_wdata, 32'hE2000003);
        tick();

        // Base load coinciding with a completing write
        send(3'b001, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000004);
        check("bl_pop_addr_pre", {24'd0, mem_addr}, 32'h01);
        base_load = 1'b1; base_addr = 8'h40;
        tick();
        base_load = 1'b0;
        check("bl_pop_level", {29'd0, level}, 32'd0);
        check("bl_pop_addr", {24'd0, mem_addr}, 32'h40);

        // Reset in mid-operation with noisy inputs
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(3'b011, 4'h1, 4'h2, 4'h3, 4'h0, 24'(k));
        check("mr_level3", {29'd0, level}, 32'd3);
        send(3'b111, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0);
        check("mr_ill_level", {29'd0, level}, 32'd3);
        check("mr_ill_err", {31'd0, err}, 32'd1);
        rst = 1'b0; in_valid = 1'b1; in_kind = 3'b001; base_load = 1'b1; base_addr = 8'h77;
        mem_ready = 1'b1;
        tick();
        check("mr_level", {29'd0, level}, 32'd0);
        check("mr_we", {31'd0, mem_we}, 32'd0);
        check("mr_addr", {24'd0, mem_addr}, 32'h00);
        check("mr_err", {31'd0, err}, 32'd0);
        check("mr_wrap", {31'd0, wrap}, 32'd0);
        check("mr_wdata", mem_wdata, 32'd0);
        check("mr_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1; in_valid = 1'b0; base_load = 1'b0;
        tick();
        check("post_rst_level", {29'd0, level}, 32'd0);
        check("post_rst_addr", {24'd0, mem_addr}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low: clk in 1, rising-edge clock; rst in 1, synchronous active-low reset.
REQ-002 SHALL have in_valid in 1: instruction fields present.
REQ-003 SHALL have in_ready out 1: encoder can accept; equals FIFO not full.
REQ-004 SHALL have in_kind in 3: 000 DP-R, 001 DP-I, 010 LDR-R, 011 LDR-I, 100 STR-R, 101 STR-I, 110 B, 111 illegal.
REQ-005 SHALL have in_cmd in 4, in_rn in 4, in_rd in 4, in_rm in 4: instruction fields.
REQ-006 SHALL have in_imm in 24: immediate; bits[7:0] for I forms, all 24 bits for B.
REQ-007 SHALL have base_load in 1 and base_addr in 8: load the write pointer.
REQ-008 SHALL have mem_ready in 1: instruction memory accepts the current write.
REQ-009 SHALL have mem_we out 1, mem_addr out 8, mem_wdata out 32: instruction memory write port.
REQ-010 SHALL have level out 3: FIFO occupancy, 0..4.
REQ-011 SHALL have err out 1: sticky illegal-kind flag.
REQ-012 SHALL have wrap out 1: sticky address wrap-around flag.

Function
REQ-013 SHALL encode each word as: [31:28]=4'b1110; [27:26]=00 for DP, 01 for LDR/STR, 10 for B; all other bits 0 unless set by REQ-014 to REQ-016.
REQ-014 SHALL, for DP/LDR/STR, set [25]=1 for I forms and 0 for R forms; [24:21]=in_cmd; [19:16]=in_rn; [15:12]=in_rd.
REQ-015 SHALL put [7:0]=in_imm[7:0] for I forms and [3:0]=in_rm for R forms; [20]=1 for STR, 0 for LDR and DP.
REQ-016 SHALL, for B, set [23:0]=in_imm and [25:24]=00.
REQ-017 SHALL treat a handshake as in_valid and in_ready high at a rising edge; the encoded word is pushed into a 4-entry FIFO at that edge.
REQ-018 SHALL drive in_ready = (level != 4), independent of mem_ready; a push is refused when full, even if a pop occurs in the same cycle.
REQ-019 SHALL, on an illegal in_kind handshake, consume the input, push nothing, and set err=1.
REQ-020 SHALL drive mem_we = (level != 0) and mem_wdata = the FIFO head; a write completes when mem_we and mem_ready are both high at an edge.
REQ-021 SHALL, on write completion, pop the head and increment mem_addr modulo 256.
REQ-022 SHALL set wrap=1 when mem_addr goes from 0xFF to 0x00.
REQ-023 SHALL give one-cycle latency: a word accepted at edge N appears with mem_we=1 in the cycle after edge N when the FIFO was empty.
REQ-024 SHALL keep level unchanged on a simultaneous push and pop; otherwise level changes by +1 or -1.
REQ-025 SHALL preserve order: words are written in acceptance order and each is written exactly once.
REQ-026 SHALL load mem_addr=base_addr on base_load; a write completing in the same cycle still pops, and base_load wins the address update.
REQ-027 SHALL hold mem_wdata and mem_addr stable while mem_we=1 and mem_ready=0.

Reset
REQ-028 SHALL, when rst=0 at an edge, set level=0, mem_we=0, mem_addr=0x00, err=0, wrap=0, in_ready=1, and mem_wdata=0.
REQ-029 SHALL discard FIFO contents on reset mid-operation; no write completes at the reset edge.
REQ-030 SHALL ignore in_valid, base_load and mem_ready while rst=0.

Verification
REQ-031 SHALL cover: DP-I cmd=4, rn=1, rd=2, imm=0x05, mem_ready=1 -> mem_wdata=0xE2812005 at mem_addr=0x00, one cycle after acceptance; DP-R cmd=2, rn=3, rd=4, rm=5 -> 0xE0434005.
REQ-032 SHALL cover: STR-I cmd=0xC, rn=1, rd=0, imm=0x04 -> 0xE7910004; B imm=0x000010 -> 0xE8000010; in_rm is ignored in I forms.
REQ-033 SHALL cover: 5 words offered with mem_ready=0 -> 4 accepted, level=4, in_ready=0; then mem_ready=1 -> writes to addresses 0..3 in order, then the 5th word is accepted.
REQ-034 SHALL cover: base_load with base_addr=0xFE, then 3 words -> addresses 0xFE, 0xFF, 0x00, and wrap=1.
REQ-035 SHALL cover: in_kind=111 handshake -> err=1, level unchanged, no mem_we.
REQ-036 SHALL cover: rst=0 with level=3 -> next cycle level=0, mem_we=0, mem_addr=0x00, err=0, wrap=0.
